// File: rtl/vproc_pkg.sv
// Shared types and default sizes for the vector processor execute-stage blocks.
package vproc_pkg;

    localparam int VPU_DATA_W = 8;
    localparam int VPU_LANES  = 4;
    localparam int VPU_ADDR_W = 10;

    typedef enum logic [1:0] {
        MEM_GV = 2'b00,
        MEM_GE = 2'b01,
        MEM_CV = 2'b10,
        MEM_CE = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        LAST = 2'b10,
        DONE = 2'b11
    } mem_state_e;

    function automatic logic op_is_load(input mem_op_e op);
        return (op == MEM_CV) || (op == MEM_CE);
    endfunction

    function automatic logic op_is_vec(input mem_op_e op);
        return (op == MEM_GV) || (op == MEM_CV);
    endfunction

endpackage

// File: rtl/vec_mem_unit.sv
// Multi-cycle load/store engine: moves one element per cycle between the
// register files and a single-port synchronous data RAM.
module vec_mem_unit
    import vproc_pkg::*;
#(
    parameter int DATA_W = VPU_DATA_W,
    parameter int LANES  = VPU_LANES,
    parameter int ADDR_W = VPU_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cl_mem_st,
    input  logic [1:0]              cl_mem_op,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*DATA_W-1:0] vec_wdata,
    input  logic [DATA_W-1:0]       esc_wdata,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_we,
    output logic                    ram_re,
    output logic [DATA_W-1:0]       ram_wdata,
    input  logic [DATA_W-1:0]       ram_rdata,
    output logic [LANES*DATA_W-1:0] vec_rdata,
    output logic [DATA_W-1:0]       esc_rdata,
    output logic                    mem_rdy,
    output logic [1:0]              state_dbg
);

    // Handshake: cl_mem_st is a level request, accepted only in IDLE; it must
    // stay high until mem_rdy pulses for one cycle (in DONE). Dropping it
    // early aborts the operation without a mem_rdy pulse.

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    mem_state_e              state_q, state_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        last_idx;
    logic [CNT_W-1:0]        cap_lane;
    mem_op_e                 op_q;
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*DATA_W-1:0] vwd_q;
    logic [DATA_W-1:0]       ewd_q;
    logic [LANES*DATA_W-1:0] vec_q;
    logic [DATA_W-1:0]       esc_q;
    logic                    is_load;
    logic                    is_vec;
    logic                    cap_vec;
    logic                    cap_esc;

    assign is_load   = op_is_load(op_q);
    assign is_vec    = op_is_vec(op_q);
    assign last_idx  = is_vec ? CNT_W'(LANES - 1) : '0;
    assign vec_rdata = vec_q;
    assign esc_rdata = esc_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_wdata = '0;
        mem_rdy   = 1'b0;
        cap_vec   = 1'b0;
        cap_esc   = 1'b0;
        cap_lane  = idx_q - CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (cl_mem_st) begin
                    state_d = XFER;
                    idx_d   = '0;
                end
            end
            XFER: begin
                ram_addr = base_q + ADDR_W'(idx_q);
                if (is_load) begin
                    // Read data lags the address by one cycle, so this cycle
                    // lands the element requested on the previous one.
                    ram_re  = 1'b1;
                    cap_vec = is_vec && (idx_q != '0);
                end else begin
                    ram_we    = 1'b1;
                    ram_wdata = is_vec ? vwd_q[idx_q*DATA_W +: DATA_W] : ewd_q;
                end
                idx_d = idx_q + CNT_W'(1);
                if (idx_q == last_idx) begin
                    state_d = is_load ? LAST : DONE;
                end
                if (!cl_mem_st) begin
                    state_d = IDLE;
                end
            end
            LAST: begin
                if (!cl_mem_st) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    cap_lane = last_idx;
                    cap_vec  = is_vec;
                    cap_esc  = !is_vec;
                end
            end
            DONE: begin
                mem_rdy = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_q    <= MEM_GV;
            base_q  <= '0;
            vwd_q   <= '0;
            ewd_q   <= '0;
            vec_q   <= '0;
            esc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && cl_mem_st) begin
                op_q   <= mem_op_e'(cl_mem_op);
                base_q <= base_addr;
                vwd_q  <= vec_wdata;
                ewd_q  <= esc_wdata;
            end
            if (cap_vec) begin
                vec_q[cap_lane*DATA_W +: DATA_W] <= ram_rdata;
            end
            if (cap_esc) begin
                esc_q <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vec_mem_unit.sv
// Scoreboard bench for vec_mem_unit: a word-array reference model predicts RAM
// traffic and load results; a negedge monitor checks every strobe and mem_rdy.
module tb_vec_mem_unit;
    import vproc_pkg::*;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cl_mem_st;
    logic [1:0]              cl_mem_op;
    logic [ADDR_W-1:0]       base_addr;
    logic [LANES*DATA_W-1:0] vec_wdata;
    logic [DATA_W-1:0]       esc_wdata;
    logic [ADDR_W-1:0]       ram_addr;
    logic                    ram_we;
    logic                    ram_re;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;
    logic [LANES*DATA_W-1:0] vec_rdata;
    logic [DATA_W-1:0]       esc_rdata;
    logic                    mem_rdy;
    logic [1:0]              state_dbg;

    always #5 clk = ~clk;

    vec_mem_unit #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cl_mem_st (cl_mem_st),
        .cl_mem_op (cl_mem_op),
        .base_addr (base_addr),
        .vec_wdata (vec_wdata),
        .esc_wdata (esc_wdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .vec_rdata (vec_rdata),
        .esc_rdata (esc_rdata),
        .mem_rdy   (mem_rdy),
        .state_dbg (state_dbg)
    );

    // Behavioural 1-cycle-latency RAM
    logic       ram_init;
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 37 + 11);
            ram_rdata <= '0;
        end else begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= ram[ram_addr];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] exp_vec;
    logic [7:0]  exp_esc;
    bit          vec_known;

    // {cycle[15:0], addr[9:0], data[7:0]}
    logic [33:0] wr_q[$];
    logic [33:0] rd_q[$];
    // {cycle[15:0], vec_known, vec[31:0], esc[7:0]}
    logic [56:0] exp_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s actual=unexpected required=none (cycle %0d)", name, cyc);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [33:0] e;
        logic [56:0] r;
        if (mon_en) begin
            if (ram_we && ram_re) flag("we_re_overlap");
            if (ram_we) begin
                if (wr_q.size() == 0) flag("ram_we");
                else begin
                    e = wr_q.pop_front();
                    check("ram_write", {cyc[15:0], ram_addr, ram_wdata}, e);
                end
            end
            if (ram_re) begin
                if (rd_q.size() == 0) flag("ram_re");
                else begin
                    e = rd_q.pop_front();
                    check("ram_read", {cyc[15:0], ram_addr}, e[33:8]);
                end
            end
            if (mem_rdy) begin
                if (exp_q.size() == 0) flag("mem_rdy");
                else begin
                    r = exp_q.pop_front();
                    check("rdy_cycle", cyc[15:0], r[56:41]);
                    if (r[40]) check("vec_rdata", vec_rdata, r[39:8]);
                    check("esc_rdata", esc_rdata, r[7:0]);
                end
            end
        end
    end

    task automatic scramble();
        cl_mem_op = 2'($urandom_range(0, 3));
        base_addr = 10'($urandom);
        vec_wdata = $urandom;
        esc_wdata = 8'($urandom);
    endtask

    // Called at #1 after a posedge with the DUT in IDLE. abort_k < 0: run to
    // completion; otherwise stop (cl_mem_st drop or rst) after element abort_k.
    task automatic issue(input logic [1:0] op, input logic [9:0] base, input logic [31:0] vwd,
                         input logic [7:0] ewd, input bit keep, input int abort_k, input bit by_rst);
        bit          load, vec;
        int          n, lat, cnt, c;
        logic [9:0]  a;
        logic [7:0]  d;
        logic [31:0] loaded;
        load   = op[1];
        vec    = !op[0];
        n      = vec ? LANES : 1;
        lat    = load ? n + 2 : n + 1;
        cnt    = (abort_k >= 0) ? abort_k + 1 : n;
        c      = cyc;
        loaded = '0;
        cl_mem_st = 1'b1;
        cl_mem_op = op;
        base_addr = base;
        vec_wdata = vwd;
        esc_wdata = ewd;
        for (int i = 0; i < cnt; i++) begin
            a = base + 10'(i);
            if (!load) begin
                d = vec ? vwd[i*8 +: 8] : ewd;
                ref_mem[a] = d;
                wr_q.push_back({16'(c + i + 1), a, d});
            end else begin
                rd_q.push_back({16'(c + i + 1), a, 8'h00});
                loaded[i*8 +: 8] = ref_mem[a];
            end
        end
        if (abort_k < 0) begin
            if (load && vec) begin
                exp_vec   = loaded;
                vec_known = 1'b1;
            end
            if (load && !vec) exp_esc = loaded[7:0];
            exp_q.push_back({16'(c + lat), vec_known, exp_vec, exp_esc});
            for (int t = 0; t < lat; t++) begin
                @(posedge clk);
                #1;
                scramble();
            end
            if (!keep) cl_mem_st = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            for (int t = 0; t <= abort_k; t++) begin
                @(posedge clk);
                #1;
                scramble();
            end
            if (by_rst) rst = 1'b1;
            cl_mem_st = 1'b0;
            @(posedge clk);
            #1;
            if (by_rst) begin
                rst       = 1'b0;
                exp_vec   = '0;
                exp_esc   = '0;
                vec_known = 1'b1;
                check("rst_ctrl_outputs", {ram_we, ram_re, mem_rdy, ram_addr, ram_wdata, esc_rdata}, '0);
                check("rst_vec_rdata", vec_rdata, '0);
            end else if (load && vec) begin
                vec_known = 1'b0;
            end
        end
    endtask

    initial begin
        bit         keep, prev_keep;
        logic [1:0] op;
        int         k;
        rst       = 1'b1;
        ram_init  = 1'b1;
        cl_mem_st = 1'b0;
        cl_mem_op = '0;
        base_addr = '0;
        vec_wdata = '0;
        esc_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
        exp_vec   = '0;
        exp_esc   = '0;
        vec_known = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {ram_we, ram_re, mem_rdy, ram_addr, ram_wdata, state_dbg}, '0);
        check("reset_rdata", {vec_rdata, esc_rdata}, '0);
        rst      = 1'b0;
        ram_init = 1'b0;
        mon_en   = 1'b1;

        // Directed cases
        issue(MEM_GV, 10'h010, 32'h44332211, 8'h00, 1'b0, -1, 1'b0);
        issue(MEM_CV, 10'h010, 32'h0, 8'h00, 1'b0, -1, 1'b0);
        check("cv_after_gv", vec_rdata, 32'h44332211);
        issue(MEM_GE, 10'h3FF, 32'hDEADBEEF, 8'hA5, 1'b0, -1, 1'b0);
        issue(MEM_CE, 10'h3FF, 32'h0, 8'h00, 1'b0, -1, 1'b0);
        check("ce_after_ge", esc_rdata, 8'hA5);
        check("vec_held_by_scalar", vec_rdata, 32'h44332211);
        issue(MEM_GV, 10'h3FE, 32'h8877_6655, 8'h00, 1'b0, -1, 1'b0);
        issue(MEM_CV, 10'h3FE, 32'h0, 8'h00, 1'b1, -1, 1'b0);
        issue(MEM_CV, 10'h010, 32'h0, 8'h00, 1'b0, -1, 1'b0);
        check("cv_wrap", vec_rdata, 32'h44332211);
        issue(MEM_GV, 10'h100, 32'hCAFEF00D, 8'h00, 1'b0, 1, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(MEM_CV, 10'h200, 32'h0, 8'h00, 1'b0, 2, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic
        prev_keep = 1'b0;
        for (int i = 0; i < 80; i++) begin
            op   = 2'($urandom_range(0, 3));
            keep = (i < 79) && ($urandom_range(0, 3) == 0);
            k    = -1;
            if (!prev_keep && !op[0] && $urandom_range(0, 7) == 0) begin
                k    = $urandom_range(0, LANES - 1);
                keep = 1'b0;
            end
            issue(op, 10'($urandom), $urandom, 8'($urandom), keep, k, 1'b0);
            prev_keep = keep;
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end

        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("wr_q_drained", 64'(wr_q.size()), 0);
        check("rd_q_drained", 64'(rd_q.size()), 0);
        check("exp_q_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
